// File: rtl/pc_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage_pkg
// Shared constants and types for the instruction fetch stage.
//   DEFAULT_RESET_PC : default PC loaded on reset
//   NOP_INSTR        : encoding placed in IF/ID for a bubble
//   PC_INCR          : sequential PC increment (one 32-bit word)
//   pc_sel_e         : source selection for the next PC
//   if_id_t          : IF/ID pipeline register contents
// -----------------------------------------------------------------------------
package pc_fetch_stage_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] PC_INCR          = 32'd4;

   typedef enum logic [1:0] {
      PC_SEQ,
      PC_BRANCH,
      PC_JUMP,
      PC_HOLD
   } pc_sel_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } if_id_t;

endpackage

// File: rtl/pc_fetch_stage_target_calc.sv
// -----------------------------------------------------------------------------
// pc_target_calc
// Combinational branch and jump target generation for the fetch stage.
// Ports:
//   if_id_pc4     (in, 32)  : PC+4 of the instruction held in IF/ID
//   branch_offset (in, 32)  : sign-extended word offset of the branch
//   jump_index    (in, 26)  : J-type instruction index
//   branch_target (out, 32) : if_id_pc4 + (branch_offset << 2), wraps mod 2^32
//   jump_target   (out, 32) : {if_id_pc4[31:28], jump_index, 2'b00}
// -----------------------------------------------------------------------------
module pc_target_calc
   import pc_fetch_stage_pkg::*;
(
   input  logic [31:0] if_id_pc4,
   input  logic [31:0] branch_offset,
   input  logic [25:0] jump_index,
   output logic [31:0] branch_target,
   output logic [31:0] jump_target
);

   // Offset bits shifted out of the top are dropped on purpose: the sum is
   // defined modulo 2^32, so negative offsets land correctly by wrap-around.
   assign branch_target = if_id_pc4 + {branch_offset[29:0], 2'b00};

   // Jumps stay inside the current 256 MB region selected by the upper nibble.
   assign jump_target   = {if_id_pc4[31:28], jump_index, 2'b00};

endmodule

// File: rtl/pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
// Parameters:
//   RESET_PC         : PC value loaded on reset
// Ports:
//   clk              (in)      : clock, all state updates on the rising edge
//   rst              (in)      : synchronous active-high reset, overrides all
//   stall            (in)      : hold PC and IF/ID
//   flush            (in)      : replace IF/ID with a bubble
//   branch_taken     (in)      : redirect to branch target (beats jump)
//   branch_offset    (in, 32)  : sign-extended branch immediate
//   jump             (in)      : redirect to jump target
//   jump_index       (in, 26)  : J-type instruction index
//   imem_addr        (out, 32) : instruction memory address (= PC)
//   imem_rdata       (in, 32)  : instruction word, combinational from imem_addr
//   if_id_instr      (out, 32) : registered instruction
//   if_id_pc4        (out, 32) : registered PC+4 of that instruction
//   if_id_valid      (out)     : IF/ID holds a real instruction
//   imm_field        (out, 16) : if_id_instr[15:0] for sign extension
//   stall_cnt        (out, 32) : saturating stall cycle count
// Configuration:
//   FETCH_STALL_CNT_EN : when defined, adds the stall_cnt port and counter.
// -----------------------------------------------------------------------------
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [15:0] imm_field
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic        redirect;
   pc_sel_e     pc_sel;
   if_id_t      if_id;

   pc_target_calc u_target_calc (
      .if_id_pc4     (if_id.pc4),
      .branch_offset (branch_offset),
      .jump_index    (jump_index),
      .branch_target (branch_target),
      .jump_target   (jump_target)
   );

   assign pc_plus4 = pc + PC_INCR;
   assign redirect = branch_taken | jump;

   // NOTE: every signal driven in always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      pc_sel  = PC_SEQ;
      next_pc = pc_plus4;
      if (branch_taken) begin
         pc_sel  = PC_BRANCH;
         next_pc = branch_target;
      end else if (jump) begin
         pc_sel  = PC_JUMP;
         next_pc = jump_target;
      end else if (stall) begin
         pc_sel  = PC_HOLD;
         next_pc = pc;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge, so it only takes effect on
      // a rising edge and is ordinary synchronous logic to timing tools.
      if (rst) begin
         pc          <= RESET_PC;
         if_id.instr <= NOP_INSTR;
         if_id.pc4   <= '0;
         if_id.valid <= 1'b0;
      end else begin
         pc <= next_pc;
         if (pc_sel == PC_BRANCH || pc_sel == PC_JUMP || flush) begin
            // Bubble: pc4 is left alone so a later branch/jump still
            // sees the last real PC+4.
            if_id.instr <= NOP_INSTR;
            if_id.valid <= 1'b0;
         end else if (!stall) begin
            if_id.instr <= imem_rdata;
            if_id.pc4   <= pc_plus4;
            if_id.valid <= 1'b1;
         end
      end
   end

   assign imem_addr   = pc;
   assign if_id_instr = if_id.instr;
   assign if_id_pc4   = if_id.pc4;
   assign if_id_valid = if_id.valid;
   assign imm_field   = if_id.instr[15:0];

`ifdef FETCH_STALL_CNT_EN
   // Counts cycles actually spent stalled; a redirect overrides the stall,
   // so those cycles are not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && !redirect && stall_cnt != 32'hFFFF_FFFF) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_stage
// Directed self-checking bench for pc_fetch_stage. Instruction memory returns
// {16'hC0DE, addr[15:0]}. stall_cnt checks are compiled in only when
// FETCH_STALL_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pc_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic        jump;
   logic [25:0] jump_index;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [15:0] imm_field;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

   pc_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_index    (jump_index),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .if_id_instr   (if_id_instr),
      .if_id_pc4     (if_id_pc4),
      .if_id_valid   (if_id_valid),
      .imm_field     (imm_field)
`ifdef FETCH_STALL_CNT_EN
      ,
      .stall_cnt     (stall_cnt)
`endif
   );

   function automatic logic [31:0] word(input logic [31:0] addr);
      return {16'hC0DE, addr[15:0]};
   endfunction

   task automatic idle_inputs();
      stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      branch_offset = '0; jump_index = '0;
   endtask

   // One rising edge, then settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      // Reset must win over everything else asserted in the same cycle.
      stall = 1'b1; flush = 1'b1; branch_taken = 1'b1; jump = 1'b1;
      branch_offset = 32'h0000_0100; jump_index = 26'h3FF_FFFF;
      step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got pc=%h instr=%h pc4=%h v=%b want 0/0/0/0", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
      checks++;
      if (imm_field !== 16'h0) begin
         errors++; $display("FAIL reset_imm: got %h want 0000", imm_field);
      end
`ifdef FETCH_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'h0) begin
         errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
      end
`endif
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_free_run();
      step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h4, 32'hC0DE_0000, 32'h4, 1'b1}) begin
         errors++;
         $display("FAIL free_run_1: got pc=%h instr=%h pc4=%h v=%b want 4/c0de0000/4/1", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
      step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h8, 32'hC0DE_0004, 32'h8, 1'b1}) begin
         errors++;
         $display("FAIL free_run_2: got pc=%h instr=%h pc4=%h v=%b want 8/c0de0004/8/1", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
      checks++;
      if (imm_field !== 16'h0004) begin
         errors++; $display("FAIL free_run_imm: got %h want 0004", imm_field);
      end
      for (int i = 0; i < 6; i++) step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h20, word(32'h1C), 32'h20, 1'b1}) begin
         errors++;
         $display("FAIL free_run_8: got pc=%h instr=%h pc4=%h v=%b want 20/c0de001c/20/1", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
   endtask

   task automatic test_branch();
      // Branch and jump together: branch must win. 0x20 + (-2 << 2) = 0x18.
      branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
      jump = 1'b1; jump_index = 26'h3FF_FFFF;
      step();
      idle_inputs();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h18, 32'h0, 32'h20, 1'b0}) begin
         errors++;
         $display("FAIL branch_back: got pc=%h instr=%h pc4=%h v=%b want 18/0/20/0", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
      step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h1C, word(32'h18), 32'h1C, 1'b1}) begin
         errors++;
         $display("FAIL branch_refetch: got pc=%h instr=%h pc4=%h v=%b want 1c/c0de0018/1c/1", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
      // 0x1C + (0x0FFF_FFFC << 2) = 0x4000_000C
      branch_taken = 1'b1; branch_offset = 32'h0FFF_FFFC;
      step();
      idle_inputs();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h4000_000C, 32'h0, 32'h1C, 1'b0}) begin
         errors++;
         $display("FAIL branch_fwd: got pc=%h instr=%h pc4=%h v=%b want 4000000c/0/1c/0", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
      step();
   endtask

   task automatic test_jump();
      checks++;
      if (if_id_pc4 !== 32'h4000_0010) begin
         errors++; $display("FAIL jump_setup_pc4: got %h want 40000010", if_id_pc4);
      end
      jump = 1'b1; jump_index = 26'h10;
      step();
      idle_inputs();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h4000_0040, 32'h0, 32'h4000_0010, 1'b0}) begin
         errors++;
         $display("FAIL jump_target: got pc=%h instr=%h pc4=%h v=%b want 40000040/0/40000010/0", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
   endtask

   task automatic test_stall_flush();
      // 0x4000_0010 + (0x2FFF_FFFF << 2) wraps to 0xC, then advance to 0x10.
      branch_taken = 1'b1; branch_offset = 32'h2FFF_FFFF;
      step();
      idle_inputs();
      checks++;
      if (imem_addr !== 32'hC) begin
         errors++; $display("FAIL branch_wrap_target: got %h want 0000000c", imem_addr);
      end
      step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h10, word(32'hC), 32'h10, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got pc=%h instr=%h pc4=%h v=%b want 10/c0de000c/10/1", i, imem_addr, if_id_instr, if_id_pc4, if_id_valid);
         end
      end
`ifdef FETCH_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd3) begin
         errors++; $display("FAIL stall_cnt_3: got %0d want 3", stall_cnt);
      end
`endif
      stall = 1'b0; flush = 1'b1;
      step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h14, 32'h0, 32'h10, 1'b0}) begin
         errors++;
         $display("FAIL flush_advance: got pc=%h instr=%h pc4=%h v=%b want 14/0/10/0", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
      stall = 1'b1;
      step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h14, 32'h0, 32'h10, 1'b0}) begin
         errors++;
         $display("FAIL flush_stall: got pc=%h instr=%h pc4=%h v=%b want 14/0/10/0", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
`ifdef FETCH_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd4) begin
         errors++; $display("FAIL stall_cnt_4: got %0d want 4", stall_cnt);
      end
`endif
      idle_inputs();
      step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h18, word(32'h14), 32'h18, 1'b1}) begin
         errors++;
         $display("FAIL post_flush: got pc=%h instr=%h pc4=%h v=%b want 18/c0de0014/18/1", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
   endtask

   task automatic test_stall_redirect();
      // 0x18 + (4 << 2) = 0x28; redirect overrides stall.
      stall = 1'b1; branch_taken = 1'b1; branch_offset = 32'h4;
      step();
      idle_inputs();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h28, 32'h0, 32'h18, 1'b0}) begin
         errors++;
         $display("FAIL stall_redirect: got pc=%h instr=%h pc4=%h v=%b want 28/0/18/0", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
`ifdef FETCH_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd4) begin
         errors++; $display("FAIL stall_redirect_cnt: got %0d want 4", stall_cnt);
      end
`endif
   endtask

   task automatic test_wrap();
      // 0x18 + (-8 << 2) = 0xFFFF_FFF8
      branch_taken = 1'b1; branch_offset = 32'hFFFF_FFF8;
      step();
      idle_inputs();
      checks++;
      if (imem_addr !== 32'hFFFF_FFF8) begin
         errors++; $display("FAIL wrap_branch: got %h want fffffff8", imem_addr);
      end
      step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'hFFFF_FFFC, 32'hC0DE_FFF8, 32'hFFFF_FFFC, 1'b1}) begin
         errors++;
         $display("FAIL wrap_top: got pc=%h instr=%h pc4=%h v=%b want fffffffc/c0defff8/fffffffc/1", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
      step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h0, 32'hC0DE_FFFC, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL wrap_zero: got pc=%h instr=%h pc4=%h v=%b want 0/c0defffc/0/1", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
      checks++;
      if (imm_field !== 16'hFFFC) begin
         errors++; $display("FAIL wrap_imm: got %h want fffc", imm_field);
      end
      step();
   endtask

   task automatic test_reset_mid_stall();
      stall = 1'b1;
      step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h4, 32'hC0DE_0000, 32'h4, 1'b1}) begin
         errors++;
         $display("FAIL pre_reset_stall: got pc=%h instr=%h pc4=%h v=%b want 4/c0de0000/4/1", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
      rst = 1'b1; jump = 1'b1; jump_index = 26'h10;
      step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_stall: got pc=%h instr=%h pc4=%h v=%b want 0/0/0/0", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
`ifdef FETCH_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd0) begin
         errors++; $display("FAIL reset_mid_stall_cnt: got %0d want 0", stall_cnt);
      end
`endif
      rst = 1'b0;
      idle_inputs();
      step();
      checks++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid} !== {32'h4, 32'hC0DE_0000, 32'h4, 1'b1}) begin
         errors++;
         $display("FAIL first_after_reset: got pc=%h instr=%h pc4=%h v=%b want 4/c0de0000/4/1", imem_addr, if_id_instr, if_id_pc4, if_id_valid);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_free_run();
      test_branch();
      test_jump();
      test_stall_flush();
      test_stall_redirect();
      test_wrap();
      test_reset_mid_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
